// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    NS_GO    = 2'd0,
    EW_GO    = 2'd1,
    PED_WALK = 2'd2,
    ILLEGAL  = 2'd3
  } phase_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [3:0] AN_RIGHT  = 4'b1110;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low cathodes ordered {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] v);
    return (v > DIGIT_MAX) ? DIGIT_MAX : v;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_count_sync.sv
// count_sync: two-flop synchroniser for the countdown digit, history flop
// and the single-cycle wrap strobe (0 followed by any non-zero digit).
module count_sync
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_in,
  output logic [3:0] d,
  output logic       wrap
);

  logic [3:0] s1_q;
  logic [3:0] s2_q;
  logic [3:0] prv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= DIGIT_MAX;
      s2_q  <= DIGIT_MAX;
      prv_q <= DIGIT_MAX;
    end else begin
      s1_q  <= count_in;
      s2_q  <= s1_q;
      prv_q <= s2_q;
    end
  end

  assign d    = s2_q;
  assign wrap = (prv_q == 4'd0) && (s2_q != 4'd0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic phase controller: sequences NS/EW lamps from the countdown digit
// and drives one seven-segment digit. Define TRAFFIC_PED_EN for pedestrian walk.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int YEL_SECS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_in,
`ifdef TRAFFIC_PED_EN
  input  logic       ped_req,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [1:0] phase,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam logic [3:0] YEL_D = 4'(YEL_SECS);

  logic [3:0] d;
  logic [3:0] d_lamp;
  logic       wrap;
  logic       ped_pending;

  phase_e state_q, state_d;

  logic [2:0] ns_d, ew_d;
  logic       walk_d;
  logic [6:0] seg_d;
  logic [2:0] active_lamp;

  logic [2:0] ns_q, ew_q;
  logic       walk_q;
  logic [1:0] phase_q;
  logic [6:0] seg_q;

  count_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .d        (d),
    .wrap     (wrap)
  );

  assign d_lamp      = clamp_digit(d);
  assign active_lamp = (d_lamp >= YEL_D) ? GRN : YEL;

`ifdef TRAFFIC_PED_EN
  logic   ped_pending_q;
  phase_e dir_q;
  logic   enter_ped;

  // A request arriving with the serving wrap is not yet visible to the FSM,
  // so it stays latched and is served one wrap later.
  assign enter_ped   = wrap && ped_pending_q &&
                       ((state_q == NS_GO) || (state_q == EW_GO));
  assign ped_pending = ped_pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pending_q <= 1'b0;
      dir_q         <= NS_GO;
    end else begin
      if (enter_ped) begin
        ped_pending_q <= 1'b0;
        dir_q         <= state_q;
      end else if (ped_req && (state_q != PED_WALK)) begin
        ped_pending_q <= 1'b1;
      end
    end
  end
`else
  assign ped_pending = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= NS_GO;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GO: begin
        if (wrap) state_d = ped_pending ? PED_WALK : EW_GO;
      end
      EW_GO: begin
        if (wrap) state_d = ped_pending ? PED_WALK : NS_GO;
      end
      PED_WALK: begin
`ifdef TRAFFIC_PED_EN
        if (wrap) state_d = (dir_q == NS_GO) ? EW_GO : NS_GO;
`else
        state_d = NS_GO;
`endif
      end
      default: state_d = NS_GO;
    endcase
  end

  // Output decode from the upcoming state, so lamps and phase switch together.
  always_comb begin
    ns_d   = active_lamp;
    ew_d   = RED;
    walk_d = 1'b0;
    seg_d  = seg_decode(d);
    case (state_d)
      NS_GO: begin
        ns_d = active_lamp;
        ew_d = RED;
      end
      EW_GO: begin
        ns_d = RED;
        ew_d = active_lamp;
      end
      PED_WALK: begin
        ns_d = RED;
        ew_d = RED;
`ifdef TRAFFIC_PED_EN
        walk_d = 1'b1;
`endif
      end
      default: begin
        ns_d = active_lamp;
        ew_d = RED;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ns_q    <= GRN;
      ew_q    <= RED;
      walk_q  <= 1'b0;
      phase_q <= NS_GO;
      seg_q   <= seg_decode(DIGIT_MAX);
    end else begin
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      walk_q  <= walk_d;
      phase_q <= state_d;
      seg_q   <= seg_d;
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign walk     = walk_q;
  assign phase    = phase_q;
  assign seg      = seg_q;
  assign an       = AN_RIGHT;

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Downstream consumer of the 9→0 seconds countdown digit. Synchronises the digit into the fast system clock domain and detects each countdown wrap. Sequences the north-south and east-west lights through green, yellow and red. Drives the Nexys 3 seven-segment display with the current digit.

## Interface
Parameters:
- `YEL_SECS`, 3: digit values below this show yellow in the active direction. Legal range 1..9.

Ports:
- `clk` input, 1: system clock (100 MHz board clock).
- `rst` input, 1: reset is synchronous and active-high.
- `count_in` input, 4: countdown digit from the decrementer. Asynchronous to `clk`. Changes about once per second.
- `ped_req` input, 1: pedestrian request, level or pulse. Present only with `PED_EN`.
- `ns_light` output, 3: north-south lamps, ordered {R,Y,G}, one-hot.
- `ew_light` output, 3: east-west lamps, ordered {R,Y,G}, one-hot.
- `walk` output, 1: pedestrian walk lamp.
- `phase` output, 2: current state encoding, for debug LEDs.
- `seg` output, 7: cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `an` output, 4: anodes, active-low. Constant 4'b1110 (rightmost digit only).

## Operation
- Synchroniser: two flops `s1` and `s2`, plus history flop `prv`. All reset to 9.
- Clamp: a synchronised value `d` of 10..15 is treated as 9 for lamp decisions.
- Wrap event `wrap` = (`prv`==0) && (`s2`!=0). A sequence 0,0,0 is not a wrap.
- States, with `phase` encoding:
  - NS_GO = 0
  - EW_GO = 1
  - PED_WALK = 2 (`PED_EN` only)
  - Encoding 3 is illegal and goes to NS_GO on the next clock.
- Transitions on `wrap`:
  - NS_GO → EW_GO
  - EW_GO → NS_GO
- Lamps in NS_GO:
  - `ns_light` = GRN if `d` ≥ `YEL_SECS`, else YEL.
  - `ew_light` = RED.
- EW_GO mirrors NS_GO with the directions swapped.
- PED_WALK: both directions RED, `walk`=1.
- `walk`=0 in every other state.
- Never both directions non-RED in the same cycle.
- `seg`: decoded from `s2`.
  - 0..9 use standard patterns (e.g. 0 = 7'b1000000, 9 = 7'b0010000).
  - 10..15 display dash 7'b0111111.
- Mid-operation `rst`: state returns to NS_GO, sync flops reload 9, pending request cleared. The first wrap after reset requires a real 0→non-0 change on `count_in`.

## Timing
- `count_in` change at edge N appears in `s2` at N+2.
- Registered lamps, `seg`, `phase` and `walk` reflect it at edge N+3. Fixed latency is 3 clocks.
- `wrap` is a one-cycle strobe. The state changes on the same edge the lamps update.
- Reset values:
  - `ns_light`=3'b001
  - `ew_light`=3'b100
  - `walk`=0
  - `phase`=0
  - `seg`=7'b0010000
  - `an`=4'b1110
- Glitch-free: all outputs are registered. No combinational path from `count_in` to any output.

## Configuration
- `TRAFFIC_PED_EN` defined:
  - `ped_req` port exists.
  - A registered `ped_pending` is set on `ped_req`=1.
  - On `wrap` in NS_GO or EW_GO with `ped_pending`=1, go to PED_WALK instead of swapping. Clear pending and store the interrupted direction.
  - The next `wrap` goes to the opposite of the stored direction.
  - `ped_req` during PED_WALK is ignored.
  - `ped_req` in the same cycle as a `wrap` is latched, not served; it is served at the following wrap.
- Undefined: no `ped_req` port, `walk` tied 0, two-state machine, `phase` never 2.

## Structure
- Package `traffic_pkg` holds:
  - state enum
  - lamp constants RED=3'b100, YEL=3'b010, GRN=3'b001
  - `seg_decode` function
  - `AN_RIGHT`=4'b1110
- Sub-module `count_sync` holds the synchroniser, `prv` and the `wrap` strobe. It reuses `clk`/`rst` and has 4-bit `d` and `wrap` outputs.

## Test plan
- Reset, hold `count_in`=9 → `ns_light`=001, `ew_light`=100, `seg`=0010000, `phase`=0.
- Step 9→2 (YEL_SECS=3) → `ns_light`=010 exactly 3 clocks later, `ew_light` stays 100.
- Step 2→1→0→9 → single `wrap`, `phase`=1, `ew_light`=001, `ns_light`=100 3 clocks after the 9.
- Drive `count_in`=12 → `seg`=0111111, active direction green.
- `TRAFFIC_PED_EN`, pulse `ped_req` in EW_GO, then 0→9 → `phase`=2, both 100, `walk`=1. Next 0→9 → `phase`=0.
- Assert `rst` in PED_WALK → next edge `phase`=0, `walk`=0, pending cleared. A later wrap goes to EW_GO.
